// File: rtl/gbe_udp_tx_mux_if.sv
// Bus bundle for gbe_udp_tx_mux: per-channel packet inputs plus the merged gbe_tx-side stream.
// master drives the channel inputs and out_afull; slave is the mux itself.
interface gbe_udp_tx_mux_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_dvld;
    logic [NUM_CH-1:0]            in_eof;
    logic [NUM_CH*32-1:0]         in_destip;
    logic [NUM_CH*16-1:0]         in_destport;
    logic [NUM_CH-1:0]            in_afull;
    logic [NUM_CH-1:0]            in_overflow;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_dvld;
    logic                         out_eof;
    logic [31:0]                  out_destip;
    logic [15:0]                  out_destport;
    logic [CH_W-1:0]              out_ch;
    logic                         out_afull;

    modport master (
        output in_data, in_dvld, in_eof, in_destip, in_destport, out_afull,
        input  in_afull, in_overflow, out_data, out_dvld, out_eof, out_destip, out_destport, out_ch
    );

    modport slave (
        input  in_data, in_dvld, in_eof, in_destip, in_destport, out_afull,
        output in_afull, in_overflow, out_data, out_dvld, out_eof, out_destip, out_destport, out_ch
    );
endinterface

// File: rtl/gbe_udp_tx_mux.sv
// N-channel store-and-forward UDP packet aggregator with packet-level round-robin replay.
// Output lags the RAM read by 1 cycle; out_afull stalls reads, per-channel in_afull is registered (1-cycle lag).
module gbe_udp_tx_mux #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 11,
    parameter int HDR_DEPTH   = 16,
    parameter int AFULL_SPACE = 64
) (
    input  logic              app_clk,
    input  logic              app_rst_n,
    gbe_udp_tx_mux_if.slave   bus
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HL    = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
    localparam int HPW   = HL + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PW-1:0] MAX_LEN = PW'(DEPTH);

    typedef struct packed {
        logic [31:0]   ip;
        logic [15:0]   port;
        logic [PW-1:0] len;
    } hdr_t;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    logic [DATA_WIDTH-1:0] r_mem  [NUM_CH][DEPTH];
    hdr_t                  r_hmem [NUM_CH][HDR_DEPTH];

    logic [PW-1:0]  r_wr_ptr [NUM_CH];
    logic [PW-1:0]  r_commit_ptr [NUM_CH];
    logic [PW-1:0]  r_rd_ptr [NUM_CH];
    logic [PW-1:0]  r_len [NUM_CH];
    logic [HPW-1:0] r_hwr [NUM_CH];
    logic [HPW-1:0] r_hrd [NUM_CH];
    logic [NUM_CH-1:0] r_bad, r_ovf, r_afull;

    logic [PW-1:0]  w_used [NUM_CH];
    logic [HPW-1:0] w_hcnt [NUM_CH];
    logic [NUM_CH-1:0] w_dfull, w_hfull, w_hnempty, w_wen, w_hwen, w_drop, w_afull_nxt;

    state_t          r_state, w_nxt;
    logic [CH_W-1:0] r_rr, r_ch, r_o_ch, w_sel;
    logic [31:0]     r_ip, r_o_ip;
    logic [15:0]     r_port, r_o_port;
    logic [PW-1:0]   r_rem;
    logic            w_found, w_pop, w_rd, w_last;
    logic            r_out_dvld, r_out_eof;
    logic [DATA_WIDTH-1:0] r_rd_word;
    hdr_t            w_hdr;

    // Write-side status; uncommitted words of the packet in progress count as used space.
    always_comb begin
        w_dfull     = '0;
        w_hfull     = '0;
        w_hnempty   = '0;
        w_wen       = '0;
        w_hwen      = '0;
        w_drop      = '0;
        w_afull_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_used[k]      = r_wr_ptr[k] - r_rd_ptr[k];
            w_hcnt[k]      = r_hwr[k] - r_hrd[k];
            w_dfull[k]     = (w_used[k] == MAX_LEN);
            w_hfull[k]     = (w_hcnt[k] == HPW'(HDR_DEPTH));
            w_hnempty[k]   = (w_hcnt[k] != '0);
            w_wen[k]       = bus.in_dvld[k] && !r_bad[k] && !w_dfull[k] && (r_len[k] != MAX_LEN)
                             && !(bus.in_eof[k] && w_hfull[k]);
            w_hwen[k]      = w_wen[k] && bus.in_eof[k];
            w_drop[k]      = bus.in_dvld[k] && bus.in_eof[k] && !w_wen[k];
            w_afull_nxt[k] = (int'(w_used[k]) + AFULL_SPACE > DEPTH)
                             || (int'(w_hcnt[k]) + 1 >= HDR_DEPTH);
        end
    end

    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            r_bad   <= '0;
            r_ovf   <= '0;
            r_afull <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_wr_ptr[k]     <= '0;
                r_commit_ptr[k] <= '0;
                r_len[k]        <= '0;
                r_hwr[k]        <= '0;
            end
        end else begin
            r_ovf   <= w_drop;
            r_afull <= w_afull_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_hwen[k]) begin
                    r_wr_ptr[k]     <= r_wr_ptr[k] + PW'(1);
                    r_commit_ptr[k] <= r_wr_ptr[k] + PW'(1);
                    r_hwr[k]        <= r_hwr[k] + HPW'(1);
                    r_len[k]        <= '0;
                    r_bad[k]        <= 1'b0;
                end else if (w_drop[k]) begin
                    r_wr_ptr[k] <= r_commit_ptr[k];
                    r_len[k]    <= '0;
                    r_bad[k]    <= 1'b0;
                end else if (w_wen[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + PW'(1);
                    r_len[k]    <= r_len[k] + PW'(1);
                end else if (bus.in_dvld[k]) begin
                    r_bad[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge app_clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_wen[k])
                r_mem[k][r_wr_ptr[k][DEPTH_LOG2-1:0]] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (w_hwen[k])
                r_hmem[k][r_hwr[k][HL-1:0]] <= '{ip:   bus.in_destip[k*32 +: 32],
                                                  port: bus.in_destport[k*16 +: 16],
                                                  len:  r_len[k] + PW'(1)};
        end
        r_rd_word <= r_mem[r_ch][r_rd_ptr[r_ch][DEPTH_LOG2-1:0]];
    end

    // First non-empty header FIFO at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_hnempty[CH_W'((int'(r_rr) + i) % NUM_CH)]) begin
                w_found = 1'b1;
                w_sel   = CH_W'((int'(r_rr) + i) % NUM_CH);
            end
        end
    end

    assign w_hdr  = r_hmem[w_sel][r_hrd[w_sel][HL-1:0]];
    assign w_last = (r_rem == PW'(1));

    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        w_pop = 1'b0;
        w_rd  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_found) begin
                w_pop = 1'b1;
                w_nxt = ST_SEND;
            end
            ST_SEND: if (!bus.out_afull) begin
                w_rd = 1'b1;
                if (w_last) w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Output-side header copies move with the data so the next pop cannot disturb the eof beat.
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            r_rr       <= '0;
            r_ch       <= '0;
            r_ip       <= '0;
            r_port     <= '0;
            r_rem      <= '0;
            r_o_ch     <= '0;
            r_o_ip     <= '0;
            r_o_port   <= '0;
            r_out_dvld <= 1'b0;
            r_out_eof  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_rd_ptr[k] <= '0;
                r_hrd[k]    <= '0;
            end
        end else begin
            r_out_dvld <= w_rd;
            r_out_eof  <= w_rd && w_last;
            if (w_pop) begin
                r_ch         <= w_sel;
                r_ip         <= w_hdr.ip;
                r_port       <= w_hdr.port;
                r_rem        <= w_hdr.len;
                r_hrd[w_sel] <= r_hrd[w_sel] + HPW'(1);
            end
            if (w_rd) begin
                r_rd_ptr[r_ch] <= r_rd_ptr[r_ch] + PW'(1);
                r_rem          <= r_rem - PW'(1);
                r_o_ch         <= r_ch;
                r_o_ip         <= r_ip;
                r_o_port       <= r_port;
                if (w_last)
                    r_rr <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    assign bus.in_afull     = r_afull;
    assign bus.in_overflow  = r_ovf;
    assign bus.out_data     = r_out_dvld ? r_rd_word : '0;
    assign bus.out_dvld     = r_out_dvld;
    assign bus.out_eof      = r_out_eof;
    assign bus.out_destip   = r_o_ip;
    assign bus.out_destport = r_o_port;
    assign bus.out_ch       = r_o_ch;
endmodule

// File: tb/tb_gbe_udp_tx_mux.sv
// Scoreboard bench for gbe_udp_tx_mux: expected beats queued at stimulus time, compared as the mux emits them.
module tb_gbe_udp_tx_mux;
    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int DL2 = 7;
    localparam int HD  = 4;
    localparam int AS  = 16;

    logic app_clk = 1'b0;
    logic app_rst_n;
    always #5 app_clk = ~app_clk;

    gbe_udp_tx_mux_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus_if ();

    gbe_udp_tx_mux #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .HDR_DEPTH(HD), .AFULL_SPACE(AS)
    ) dut (
        .app_clk  (app_clk),
        .app_rst_n(app_rst_n),
        .bus      (bus_if)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] port;
        logic [0:0]  ch;
    } beat_t;

    beat_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_eof = 0;
    int    n_ovf[NCH];
    logic  prev_afull = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge app_clk) begin : mon
        beat_t e;
        if (bus_if.out_dvld) begin
            if (sb_q.size() == 0) begin
                chk_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk_eq("beat_data", bus_if.out_data, e.d);
                chk_eq("beat_hdr", {bus_if.out_eof, bus_if.out_destip, bus_if.out_destport, bus_if.out_ch},
                       {e.eof, e.ip, e.port, e.ch});
            end
            if (bus_if.out_eof) n_eof++;
        end else begin
            chk_eq("idle_zero", {bus_if.out_eof, bus_if.out_data}, 64'd0);
        end
        if (prev_afull) chk_eq("blocked_read", bus_if.out_dvld, 64'd0);
        prev_afull = bus_if.out_afull;
        for (int c = 0; c < NCH; c++)
            if (bus_if.in_overflow[c]) n_ovf[c]++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge app_clk);
            #1;
        end
    endtask

    task automatic exp_pkt(input int ch, input int len, input logic [7:0] base,
                           input logic [31:0] ip, input logic [15:0] port);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = base + 8'(i);
            b.eof  = (i == len - 1);
            b.ip   = ip;
            b.port = port;
            b.ch   = 1'(ch);
            sb_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input int ch, input int len, input logic [7:0] base,
                            input logic [31:0] ip, input logic [15:0] port, input bit keep);
        for (int i = 0; i < len; i++) begin
            bus_if.in_data                 = '0;
            bus_if.in_data[ch*DW +: DW]    = base + 8'(i);
            bus_if.in_dvld                 = '0;
            bus_if.in_dvld[ch]             = 1'b1;
            bus_if.in_eof                  = '0;
            bus_if.in_eof[ch]              = (i == len - 1);
            bus_if.in_destip[ch*32 +: 32]  = ip;
            bus_if.in_destport[ch*16 +: 16] = port;
            tick(1);
        end
        bus_if.in_dvld = '0;
        bus_if.in_eof  = '0;
        if (keep) exp_pkt(ch, len, base, ip, port);
    endtask

    task automatic send_pair();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                bus_if.in_dvld     = 2'b11;
                bus_if.in_eof      = (i == 3) ? 2'b11 : 2'b00;
                bus_if.in_data     = {8'(8'h80 + 4*p + i), 8'(8'h40 + 4*p + i)};
                bus_if.in_destip   = {32'(32'hC0A80100 + p), 32'(32'hC0A80000 + p)};
                bus_if.in_destport = {16'h1001, 16'h1000};
                tick(1);
            end
            exp_pkt(0, 4, 8'(8'h40 + 4*p), 32'(32'hC0A80000 + p), 16'h1000);
            exp_pkt(1, 4, 8'(8'h80 + 4*p), 32'(32'hC0A80100 + p), 16'h1001);
        end
        bus_if.in_dvld = '0;
        bus_if.in_eof  = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        tick(3);
        chk_eq(tag, sb_q.size(), 64'd0);
    endtask

    task automatic do_reset();
        app_rst_n = 1'b0;
        tick(2);
        app_rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int e0, o0;
        bus_if.in_data     = '0;
        bus_if.in_dvld     = '0;
        bus_if.in_eof      = '0;
        bus_if.in_destip   = '0;
        bus_if.in_destport = '0;
        bus_if.out_afull   = 1'b0;
        app_rst_n          = 1'b0;
        tick(3);
        chk_eq("rst_dvld", bus_if.out_dvld, 64'd0);
        chk_eq("rst_data", bus_if.out_data, 64'd0);
        chk_eq("rst_eof", bus_if.out_eof, 64'd0);
        chk_eq("rst_dest", {bus_if.out_destip, bus_if.out_destport, bus_if.out_ch}, 64'd0);
        chk_eq("rst_flags", {bus_if.in_afull, bus_if.in_overflow}, 64'd0);
        app_rst_n = 1'b1;
        tick(2);
        chk_eq("idle_afull", bus_if.in_afull, 64'd0);

        // single 10-byte packet
        e0 = n_eof;
        send_pkt(0, 10, 8'h00, 32'h0A000001, 16'h1234, 1'b1);
        wait_drain("t1_drain", 200);
        chk_eq("t1_eof_cnt", n_eof - e0, 64'd1);

        // two channels, three packets each, round-robin from channel 0
        do_reset();
        e0 = n_eof;
        send_pair();
        wait_drain("t2_drain", 300);
        chk_eq("t2_eof_cnt", n_eof - e0, 64'd6);

        // 100-byte packet under intermittent backpressure
        bus_if.out_afull = 1'b1;
        e0 = n_eof;
        send_pkt(0, 100, 8'h20, 32'h0A000003, 16'h2222, 1'b1);
        for (int c = 0; c < 2000 && sb_q.size() != 0; c++) begin
            bus_if.out_afull = (c % 3 == 0);
            tick(1);
        end
        bus_if.out_afull = 1'b0;
        wait_drain("t3_drain", 50);
        chk_eq("t3_eof_cnt", n_eof - e0, 64'd1);

        // oversize packet dropped, following packet intact
        e0 = n_eof;
        o0 = n_ovf[0];
        send_pkt(0, (1 << DL2) + 6, 8'h00, 32'h0A000004, 16'h3333, 1'b0);
        chk_eq("t4_ovf_pulse", bus_if.in_overflow[0], 64'd1);
        tick(1);
        chk_eq("t4_ovf_width", bus_if.in_overflow[0], 64'd0);
        send_pkt(0, 5, 8'hA0, 32'h0A000005, 16'h4444, 1'b1);
        wait_drain("t4_drain", 200);
        chk_eq("t4_eof_cnt", n_eof - e0, 64'd1);
        chk_eq("t4_ovf_cnt", n_ovf[0] - o0, 64'd1);
        chk_eq("t4_afull_clear", bus_if.in_afull[0], 64'd0);

        // header FIFO fill on ch1 with the output stalled; first packet sits in the arbiter
        bus_if.out_afull = 1'b1;
        e0 = n_eof;
        for (int j = 0; j < 5; j++) begin
            send_pkt(1, 4, 8'(8'h10 * j), 32'(32'h0B000000 + j), 16'h5555, 1'b1);
            tick(2);
            if (j == 2) chk_eq("t5_afull_lo", bus_if.in_afull[1], 64'd0);
            if (j == 3) chk_eq("t5_afull_hi", bus_if.in_afull[1], 64'd1);
        end
        o0 = n_ovf[1];
        send_pkt(1, 4, 8'hF0, 32'h0B0000FF, 16'h5555, 1'b0);
        chk_eq("t5_ovf_pulse", bus_if.in_overflow[1], 64'd1);
        bus_if.out_afull = 1'b0;
        wait_drain("t5_drain", 300);
        chk_eq("t5_eof_cnt", n_eof - e0, 64'd5);
        chk_eq("t5_ovf_cnt", n_ovf[1] - o0, 64'd1);

        // reset mid-packet
        send_pkt(0, 20, 8'h60, 32'h0A000006, 16'h6666, 1'b1);
        for (int c = 0; c < 200 && sb_q.size() > 15; c++) tick(1);
        chk_eq("t6_progress", sb_q.size() <= 15, 64'd1);
        app_rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_out", {bus_if.out_dvld, bus_if.out_eof, bus_if.out_data}, 64'd0);
        chk_eq("t6_rst_dest", {bus_if.out_destip, bus_if.out_destport}, 64'd0);
        sb_q.delete();
        tick(1);
        app_rst_n = 1'b1;
        tick(30);
        chk_eq("t6_afull", bus_if.in_afull, 64'd0);
        e0 = n_eof;
        send_pkt(1, 8, 8'hC0, 32'h0A000007, 16'h7777, 1'b1);
        wait_drain("t6_drain", 200);
        chk_eq("t6_eof_cnt", n_eof - e0, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
